// File: rtl/m_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, read-tag bit indices
// and default address/data widths.
package m_dmem_arbiter_pkg;

   localparam logic [0:0] ST_ARB   = 1'b0;
   localparam logic [0:0] ST_FORCE = 1'b1;

   localparam int TAG_P = 1;
   localparam int TAG_H = 0;

   localparam int DEF_AW = 12;
   localparam int DEF_DW = 32;

endpackage

// File: rtl/m_dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment and
// the count sticks at MAX.
module m_sat_counter #(
   parameter int           W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/m_dmem_arbiter.sv
// Arbitrates one single-port synchronous data RAM between the pipeline MEM stage (P) and a
// host port (H). Define DMEM_ARB_STARVE_EN to bound H starvation with a forced grant.
module m_dmem_arbiter
   import m_dmem_arbiter_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int DW           = DEF_DW,
   parameter int STARVE_LIMIT = 8,
   parameter int CW           = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p_valid,
   input  logic          p_we,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   output logic          p_stall,
   output logic          p_rvalid,
   output logic [DW-1:0] p_rdata,
   input  logic          h_valid,
   output logic          h_ready,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   output logic          h_rvalid,
   output logic [DW-1:0] h_rdata,
   output logic [AW-1:0] m_addr,
   output logic          m_we,
   output logic [DW-1:0] m_din,
   input  logic [DW-1:0] m_dout,
   output logic [CW-1:0] conflict_cnt
);

   logic [0:0] state;
   logic       force_h;
   logic       grant_p;
   logic       grant_h;
   logic [1:0] rd_tag;

   // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
   assign force_h = (state == ST_FORCE);
   assign grant_p = rst_n && p_valid && !force_h;
   assign grant_h = rst_n && h_valid && !grant_p;
   assign p_stall = rst_n && p_valid && !grant_p;
   assign h_ready = grant_h;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      m_addr = '0;
      m_we   = 1'b0;
      m_din  = '0;
      if (grant_p) begin
         m_addr = p_addr;
         m_we   = p_we;
         m_din  = p_wdata;
      end else if (grant_h) begin
         m_addr = h_addr;
         m_we   = h_we;
         m_din  = h_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_tag <= 2'b00;
      end else begin
         rd_tag[TAG_P] <= grant_p && !p_we;
         rd_tag[TAG_H] <= grant_h && !h_we;
      end
   end

   assign p_rvalid = rd_tag[TAG_P];
   assign h_rvalid = rd_tag[TAG_H];
   assign p_rdata  = m_dout;
   assign h_rdata  = m_dout;

   m_sat_counter #(
      .W   (CW),
      .MAX ({CW{1'b1}})
   ) u_conflict_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (p_valid && h_valid),
      .clr   (1'b0),
      .cnt   (conflict_cnt)
   );

`ifdef DMEM_ARB_STARVE_EN
   localparam logic [7:0] WAIT_MAX = 8'(STARVE_LIMIT - 1);

   logic [7:0] wait_cnt;

   m_sat_counter #(
      .W   (8),
      .MAX (WAIT_MAX)
   ) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (h_valid && !h_ready),
      .clr   (h_ready || !h_valid),
      .cnt   (wait_cnt)
   );

   // FORCE lasts exactly one cycle; if H has withdrawn, that cycle is simply idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ARB;
      end else if (state == ST_FORCE) begin
         state <= ST_ARB;
      end else if (h_valid && !grant_h && (wait_cnt == WAIT_MAX)) begin
         state <= ST_FORCE;
      end
   end
`else
   assign state = ST_ARB;
`endif

endmodule
